alu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer that drives the 4-bit ALU (ripple-carry adder + zero mux) to add wide operands.

---
 rtl/alu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial wide adder sequencer driving an external 4-bit ALU, LSB nibble first.
// Optional signed-overflow output ovf is enabled by defining ALU_SEQ_OVF_FLAG_EN.
module alu_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
  input  logic                   en,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   co,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_ci,
  output logic                   alu_s,
  input  logic [3:0]             alu_out,
  input  logic                   alu_co
`ifdef ALU_SEQ_OVF_FLAG_EN
  ,
  output logic                   ovf
`endif
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [NIBBLES-1:0][3:0] a_q, b_q, result_q;
  logic                    en_q, carry_q, co_q;
  logic [IdxW-1:0]         idx_q;
  logic                    last;

  assign last = (idx_q == IdxLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      en_q     <= 1'b0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            en_q     <= en;
            carry_q  <= ci;
            idx_q    <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
          end
        end
        StRun: begin
          result_q[idx_q] <= alu_out;
          carry_q         <= alu_co;
          idx_q           <= idx_q + 1'b1;
          // Final carry is captured here so it stays valid after DONE.
          if (last) co_q <= en_q & alu_co;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_OVF_FLAG_EN
  logic ovf_q;

  // Carry into the MSB xor carry out of the MSB gives signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last) begin
      ovf_q <= en_q & (a_q[NIBBLES-1][3] ^ b_q[NIBBLES-1][3] ^ alu_out[3] ^ alu_co);
    end
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    ready  = (state_q == StIdle);
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    alu_ci = 1'b0;
    alu_s  = 1'b0;
    if (state_q == StRun) begin
      alu_a  = a_q[idx_q];
      alu_b  = b_q[idx_q];
      alu_ci = carry_q;
      alu_s  = en_q;
    end
  end

  assign result = result_q;
  assign co     = co_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl against a behavioural model of the wide add and its timing.
module tb_alu_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         ci = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, co, alu_ci, alu_s, alu_co;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_out;
  logic [4:0]   alu_sum;
`ifdef ALU_SEQ_OVF_FLAG_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // External 4-bit ALU: adder whose sum is zeroed when not selected; carry passes through.
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci};
  assign alu_out = alu_s ? alu_sum[3:0] : 4'h0;
  assign alu_co  = alu_sum[4];

  alu_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ci     (ci),
    .en     (en),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_ci (alu_ci),
    .alu_s  (alu_s),
    .alu_out(alu_out),
    .alu_co (alu_co)
`ifdef ALU_SEQ_OVF_FLAG_EN
    ,
    .ovf    (ovf)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] lmask(input int bits);
    return (65'd1 << bits) - 65'd1;
  endfunction

  function automatic logic [64:0] full_sum(input logic [64:0] x, input logic [64:0] y,
                                           input logic c);
    return x + y + {64'd0, c};
  endfunction

  function automatic bit sovf(input logic [64:0] x, input logic [64:0] y, input logic c);
    longint sx, sy, s;
    sx = longint'(x[W-1:0]);
    sy = longint'(y[W-1:0]);
    if (x[W-1]) sx = sx - (longint'(1) << W);
    if (y[W-1]) sy = sy - (longint'(1) << W);
    s = sx + sy + longint'(c);
    return (s > ((longint'(1) << (W - 1)) - 1)) || (s < -(longint'(1) << (W - 1)));
  endfunction

  // Model: phase 0 idle, 1 running (m_k nibbles finished), 2 done.
  int          m_phase = 0;
  int          m_k = 0;
  logic [64:0] m_a = '0, m_b = '0;
  logic        m_ci = 1'b0, m_en = 1'b0;
  logic [63:0] m_res = '0;
  logic        m_co = 1'b0, m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_k     <= 0;
      m_res   <= '0;
      m_co    <= 1'b0;
      m_ovf   <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      m_ci    <= 1'b0;
      m_en    <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_a     <= 65'(a);
          m_b     <= 65'(b);
          m_ci    <= ci;
          m_en    <= en;
          m_res   <= '0;
          m_co    <= 1'b0;
          m_ovf   <= 1'b0;
          m_k     <= 0;
          m_phase <= 1;
        end
        1: begin
          m_k   <= m_k + 1;
          m_res <= m_en ? 64'(full_sum(m_a, m_b, m_ci) & lmask(4 * (m_k + 1))) : 64'd0;
          if (m_k + 1 == NIB) begin
            m_co    <= m_en & full_sum(m_a, m_b, m_ci)[W];
            m_ovf   <= m_en & sovf(m_a, m_b, m_ci);
            m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [64:0] lm;
    logic        exp_ci;
    if (chk_en) begin
      lm     = lmask(4 * m_k);
      exp_ci = full_sum(m_a & lm, m_b & lm, m_ci)[4 * m_k];
      chk("ready", 64'(ready), 64'(m_phase == 0));
      chk("busy", 64'(busy), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("result", 64'(result), m_res);
      chk("co", 64'(co), 64'(m_co));
      chk("alu_a", 64'(alu_a), (m_phase == 1) ? 64'((m_a >> (4 * m_k)) & 65'hF) : 64'd0);
      chk("alu_b", 64'(alu_b), (m_phase == 1) ? 64'((m_b >> (4 * m_k)) & 65'hF) : 64'd0);
      chk("alu_ci", 64'(alu_ci), (m_phase == 1) ? 64'(exp_ci) : 64'd0);
      chk("alu_s", 64'(alu_s), (m_phase == 1) ? 64'(m_en) : 64'd0);
`ifdef ALU_SEQ_OVF_FLAG_EN
      chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    #1;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    bit got;
    cyc    = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && cyc < 4 * NIB + 10) begin
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      #1;
      if (busy) busy_n++;
      got = done;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                        input logic ten, input bit lit, input logic [W-1:0] er,
                        input logic eco, input string nm);
    int cyc, busy_n;
    wait_ready();
    a = ta; b = tb; ci = tci; en = ten; start = 1'b1;
    wait_done(cyc, busy_n);
    chk({nm, "_latency"}, 64'(cyc), 64'(NIB + 1));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(NIB));
    if (lit) begin
      chk({nm, "_result"}, 64'(result), 64'(er));
      chk({nm, "_co"}, 64'(co), 64'(eco));
    end
  endtask

  initial begin
    int cyc, busy_n;
    logic [W-1:0] ra, rb;
    #1 rst = 1'b1;
    #2 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    #1 rst = 1'b0;

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, "t1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, "t2");
    run_op(16'h1234, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h2346, 1'b0, "t3");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, "t4");

    // start held high through RUN with different operands must be ignored
    wait_ready();
    a = 16'h1234; b = 16'h1111; ci = 1'b1; en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 a = 16'hFFFF; b = 16'hFFFF; ci = 1'b0; en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    wait_done(cyc, busy_n);
    chk("t5_done_seen", 64'(done), 64'd1);
    chk("t5_result", 64'(result), 64'h2346);
    chk("t5_co", 64'(co), 64'd0);

    // reset asserted in the second RUN cycle aborts the operation
    wait_ready();
    a = 16'hFFFF; b = 16'h0001; ci = 1'b0; en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5r_ready", 64'(ready), 64'd1);
    chk("t5r_busy", 64'(busy), 64'd0);
    chk("t5r_done", 64'(done), 64'd0);
    chk("t5r_result", 64'(result), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, "t5r_after");

`ifdef ALU_SEQ_OVF_FLAG_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, "t6a");
    chk("t6a_ovf", 64'(ovf), 64'd1);
    run_op(16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, "t6b");
    chk("t6b_ovf", 64'(ovf), 64'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, "t6c");
    chk("t6c_ovf", 64'(ovf), 64'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) ra = '1;
      if (i % 7 == 0) rb = W'(1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, '0, 1'b0,
             "rand");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
